flux_rr_scheduler: RTL and testbench

Fair flux arbiter for multi-flux HEVC dataflow actors. It chooses which flux an actor serves each cycle, from per-flux "fireable" requests, and presents the choice as a one-hot grant plus a binary tag that drives the actor's tag-indexed state and FIFO port selection. It replaces fixed lowest-index priority with rotating priority, adds a starvation watchdog, and optionally locks a flux for the duration of a block.

---
 rtl/flux_rr_scheduler.sv | 170 +++++++++++++++++
 tb/tb_flux_rr_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/flux_rr_scheduler.sv
// Rotating-priority flux arbiter with a starvation watchdog and optional block lock.
// Define BURST_LOCK_EN to compile in the block lock FSM; otherwise lock outputs are tied to 0.
module flux_rr_scheduler #(
    parameter int FLUX       = 2,
    parameter int TAG_WIDTH  = (FLUX > 1) ? $clog2(FLUX) : 1,
    parameter int MAX_WAIT   = 15,
    parameter int WAIT_WIDTH = $clog2(MAX_WAIT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLUX-1:0]      req,
    input  logic [FLUX-1:0]      blk_start,
    input  logic [FLUX-1:0]      blk_last,
    output logic [FLUX-1:0]      grant,
    output logic [TAG_WIDTH-1:0] tag,
    output logic                 grant_valid,
    output logic                 lock_active,
    output logic [TAG_WIDTH-1:0] locked_tag
);

    localparam logic [WAIT_WIDTH-1:0] WAIT_SAT = WAIT_WIDTH'(MAX_WAIT);
    localparam logic [TAG_WIDTH:0]    FLUX_W   = (TAG_WIDTH + 1)'(FLUX);
    localparam logic [TAG_WIDTH-1:0]  LAST_TAG = TAG_WIDTH'(FLUX - 1);

    logic [TAG_WIDTH-1:0]  ptr_reg;
    logic [TAG_WIDTH-1:0]  ptr_next;
    logic [WAIT_WIDTH-1:0] wait_cnt [FLUX];

    logic                 starve_found;
    logic [TAG_WIDTH-1:0] starve_idx;
    logic                 rr_found;
    logic [TAG_WIDTH-1:0] rr_idx;
    logic [TAG_WIDTH:0]   rr_cand;
    logic                 lock_hit;
    logic                 from_lock;
    logic                 any_req;
    logic [TAG_WIDTH-1:0] sel;

    // Descending scans leave the lowest qualifying index in the result.
    always_comb begin
        starve_found = 1'b0;
        starve_idx   = '0;
        for (int i = FLUX - 1; i >= 0; i--) begin
            if (req[i] && (wait_cnt[i] == WAIT_SAT)) begin
                starve_found = 1'b1;
                starve_idx   = TAG_WIDTH'(i);
            end
        end
    end

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int k = FLUX - 1; k >= 0; k--) begin
            rr_cand = {1'b0, ptr_reg} + (TAG_WIDTH + 1)'(k);
            if (rr_cand >= FLUX_W) begin
                rr_cand = rr_cand - FLUX_W;
            end
            if (req[rr_cand[TAG_WIDTH-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand[TAG_WIDTH-1:0];
            end
        end
    end

`ifdef BURST_LOCK_EN
    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    logic [0:0]           state_reg;
    logic [TAG_WIDTH-1:0] locked_tag_reg;

    assign lock_hit = (state_reg == ST_LOCKED) && req[locked_tag_reg];

    // Only the granted flux's block markers matter; a starvation grant elsewhere leaves the lock alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_UNLOCKED;
            locked_tag_reg <= '0;
        end else begin
            case (state_reg)
                ST_UNLOCKED: begin
                    if (any_req && blk_start[sel] && !blk_last[sel]) begin
                        state_reg      <= ST_LOCKED;
                        locked_tag_reg <= sel;
                    end
                end
                default: begin
                    if (any_req && (sel == locked_tag_reg) && blk_last[sel]) begin
                        state_reg      <= ST_UNLOCKED;
                        locked_tag_reg <= '0;
                    end
                end
            endcase
        end
    end

    assign lock_active = (state_reg == ST_LOCKED);
    assign locked_tag  = locked_tag_reg;
`else
    logic unused_blk;
    assign unused_blk  = ^{blk_start, blk_last};
    assign lock_hit    = 1'b0;
    assign lock_active = 1'b0;
    assign locked_tag  = '0;
`endif

    always_comb begin
        any_req   = |req;
        from_lock = 1'b0;
        sel       = '0;
        if (starve_found) begin
            sel = starve_idx;
        end else if (lock_hit) begin
            sel       = locked_tag;
            from_lock = 1'b1;
        end else if (rr_found) begin
            sel = rr_idx;
        end
    end

    assign grant       = any_req ? (FLUX'(1) << sel) : '0;
    assign tag         = any_req ? sel : '0;
    assign grant_valid = any_req;

    // Lock-path grants leave the rotation pointer where round-robin last stopped.
    always_comb begin
        ptr_next = ptr_reg;
        if (any_req && !from_lock) begin
            ptr_next = (sel == LAST_TAG) ? '0 : sel + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FLUX; gi++) begin : g_wait
            logic [WAIT_WIDTH-1:0] cnt_reg;
            logic [WAIT_WIDTH-1:0] cnt_next;

            always_comb begin
                cnt_next = cnt_reg;
                if (!req[gi] || grant[gi]) begin
                    cnt_next = '0;
                end else if (cnt_reg != WAIT_SAT) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign wait_cnt[gi] = cnt_reg;
        end
    endgenerate

endmodule

// File: tb/tb_flux_rr_scheduler.sv
// Self-checking bench for flux_rr_scheduler (FLUX=4, MAX_WAIT=15): constant vector table,
// directed corner sequences and random traffic against an integer reference model.
module tb_flux_rr_scheduler;

    localparam int FLUX     = 4;
    localparam int MAX_WAIT = 15;
    localparam int TW       = 2;

`ifdef BURST_LOCK_EN
    localparam logic [3:0] ALT_BS = 4'b0000;
`else
    localparam logic [3:0] ALT_BS = 4'b0001;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [3:0]    blk_start;
    logic [3:0]    blk_last;
    logic [3:0]    grant;
    logic [TW-1:0] tag;
    logic          grant_valid;
    logic          lock_active;
    logic [TW-1:0] locked_tag;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc    = 0;

    // Reference model state
    int m_ptr;
    int m_wait [FLUX];
    bit m_lock;
    int m_ltag;

    typedef struct {
        logic [3:0] req;
        logic [3:0] bs;
        logic [3:0] bl;
        logic [3:0] exp_grant;
        int         exp_tag;
    } vec_t;

    vec_t vecs [19];

    flux_rr_scheduler #(
        .FLUX     (FLUX),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .blk_start   (blk_start),
        .blk_last    (blk_last),
        .grant       (grant),
        .tag         (tag),
        .grant_valid (grant_valid),
        .lock_active (lock_active),
        .locked_tag  (locked_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, n_cyc);
        end
    endtask

    function automatic void model_reset();
        m_ptr  = 0;
        m_lock = 0;
        m_ltag = 0;
        for (int i = 0; i < FLUX; i++) m_wait[i] = 0;
    endfunction

    // Returns the flux the rules select, or -1 when nobody requests.
    function automatic int model_pick(input logic [3:0] r, output bit via_lock);
        int idx;
        via_lock = 0;
        for (int i = 0; i < FLUX; i++) begin
            if (r[i] && m_wait[i] >= MAX_WAIT) return i;
        end
`ifdef BURST_LOCK_EN
        if (m_lock && r[m_ltag]) begin
            via_lock = 1;
            return m_ltag;
        end
`endif
        for (int k = 0; k < FLUX; k++) begin
            idx = (m_ptr + k) % FLUX;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic void model_update(input logic [3:0] r, input logic [3:0] bs,
                                         input logic [3:0] bl, input int g, input bit via_lock);
        if (g >= 0 && !via_lock) m_ptr = (g + 1) % FLUX;
        for (int i = 0; i < FLUX; i++) begin
            if (!r[i] || i == g) m_wait[i] = 0;
            else if (m_wait[i] < MAX_WAIT) m_wait[i] = m_wait[i] + 1;
        end
`ifdef BURST_LOCK_EN
        if (g >= 0) begin
            if (!m_lock) begin
                if (bs[g] && !bl[g]) begin
                    m_lock = 1;
                    m_ltag = g;
                end
            end else if (g == m_ltag && bl[g]) begin
                m_lock = 0;
                m_ltag = 0;
            end
        end
`else
        if (bs != bl && 1'b0) m_lock = 0;
`endif
    endfunction

    // One clock: drive at the falling edge, compare 1 time unit later, advance the model.
    task automatic cycle(input logic [3:0] r, input logic [3:0] bs, input logic [3:0] bl,
                         input logic rv);
        int         g;
        bit         vl;
        logic [3:0] eg;
        @(negedge clk);
        req       = r;
        blk_start = bs;
        blk_last  = bl;
        rst       = rv;
        #1;
        n_cyc++;
        g  = model_pick(r, vl);
        eg = 4'b0000;
        if (g >= 0) eg[g] = 1'b1;
        check("grant", int'(grant), int'(eg));
        check("tag", int'(tag), (g >= 0) ? g : 0);
        check("grant_valid", int'(grant_valid), (g >= 0) ? 1 : 0);
        check("lock_active", int'(lock_active), int'(m_lock));
        check("locked_tag", int'(locked_tag), m_lock ? m_ltag : 0);
        $display("cyc %0d rst=%b req=%b bs=%b bl=%b -> grant=%b tag=%0d lock=%b/%0d",
                 n_cyc, rv, r, bs, bl, grant, tag, lock_active, locked_tag);
        if (rv) model_reset();
        else model_update(r, bs, bl, g, vl);
    endtask

    task automatic do_reset();
        cycle(4'b0000, 4'b0000, 4'b0000, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        blk_start = '0;
        blk_last  = '0;
        model_reset();
        repeat (2) @(negedge clk);

        // Constant vectors: reset state, rotation on all-request, sparse request, idle, alternation.
        vecs[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 0};
        for (int i = 0; i < 8; i++)
            vecs[1 + i] = '{4'b1111, 4'b0000, 4'b0000, 4'b0001 << (i % 4), i % 4};
        vecs[9]  = '{4'b1010, 4'b0000, 4'b0000, 4'b0010, 1};
        vecs[10] = '{4'b1010, 4'b0000, 4'b0000, 4'b1000, 3};
        vecs[11] = '{4'b1010, 4'b0000, 4'b0000, 4'b0010, 1};
        vecs[12] = '{4'b1010, 4'b0000, 4'b0000, 4'b1000, 3};
        vecs[13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 0};
        vecs[14] = '{4'b0011, ALT_BS,  4'b0000, 4'b0001, 0};
        vecs[15] = '{4'b0011, 4'b0000, 4'b0000, 4'b0010, 1};
        vecs[16] = '{4'b0011, ALT_BS,  4'b0000, 4'b0001, 0};
        vecs[17] = '{4'b0011, 4'b0000, 4'b0000, 4'b0010, 1};
        vecs[18] = '{4'b0011, ALT_BS,  4'b0000, 4'b0001, 0};
        for (int v = 0; v < 19; v++) begin
            cycle(vecs[v].req, vecs[v].bs, vecs[v].bl, 1'b0);
            check("vec_grant", int'(grant), int'(vecs[v].exp_grant));
            check("vec_tag", int'(tag), vecs[v].exp_tag);
        end
`ifndef BURST_LOCK_EN
        check("alt_no_lock", int'(lock_active), 0);
`endif

`ifdef BURST_LOCK_EN
        // Lock on flux 0 holds 15 cycles, then starving fluxes 1..3 are served in index order.
        do_reset();
        for (int c = 0; c < 15; c++) begin
            cycle(4'b1111, (c == 0) ? 4'b0001 : 4'b0000, 4'b0000, 1'b0);
            check("lock_hold_tag", int'(tag), 0);
        end
        cycle(4'b1111, 4'b0000, 4'b0000, 1'b0);
        check("starve_tag", int'(tag), 1);
        check("starve_lock_kept", int'(lock_active), 1);
        cycle(4'b1111, 4'b0000, 4'b0000, 1'b0);
        check("starve_tag2", int'(tag), 2);
        cycle(4'b1111, 4'b0000, 4'b0000, 1'b0);
        check("starve_tag3", int'(tag), 3);
        cycle(4'b1111, 4'b0000, 4'b0000, 1'b0);
        check("relock_tag", int'(tag), 0);
        check("relock_active", int'(lock_active), 1);

        // Lock on flux 2 released by blk_last; next grant is round-robin from ptr=3.
        do_reset();
        cycle(4'b0100, 4'b0100, 4'b0000, 1'b0);
        cycle(4'b0110, 4'b0000, 4'b0000, 1'b0);
        check("lock2_tag", int'(tag), 2);
        cycle(4'b0110, 4'b0000, 4'b0100, 1'b0);
        check("lock2_last_tag", int'(tag), 2);
        cycle(4'b0111, 4'b0000, 4'b0000, 1'b0);
        check("unlock_active", int'(lock_active), 0);
        check("unlock_rr_tag", int'(tag), 0);
`endif

        // Reset while (possibly) locked on flux 3 with flux 1 waiting 10 cycles.
        do_reset();
        cycle(4'b1000, 4'b1000, 4'b0000, 1'b0);
        for (int c = 0; c < 10; c++) cycle(4'b1010, 4'b0000, 4'b0000, 1'b0);
        do_reset();
        cycle(4'b1010, 4'b0000, 4'b0000, 1'b0);
        check("post_rst_lock", int'(lock_active), 0);
        check("post_rst_tag", int'(tag), 1);

        // Random traffic with sparse block markers and occasional resets.
        for (int c = 0; c < 400; c++) begin
            cycle(4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                  ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                  ($urandom_range(0, 99) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
